// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Opcode encodings, FSM states and the iterative-op classifier.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_SLTU  = 4'b1110;
    localparam logic [3:0] OP_EQ    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_iter(input logic [3:0] sel);
        return (sel == OP_MUL) || (sel == OP_MULHU) ||
               (sel == OP_DIVU) || (sel == OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Shared iterative unsigned multiply / restoring divide datapath.
// Ports: clk_i, reset_i (sync, active high), start_i pulse loads a_i/b_i
// and op_i; done_o pulses on the final step with lo_o/hi_o holding the
// post-step values (mul: product low/high; div: quotient/remainder).
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = SHW + 1;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             last;

    always_comb begin
        sum    = {1'b0, hi_q} + {1'b0, b_q};
        // Remainder shifted left with the next dividend bit from lo.
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        diff   = rem_sh[WIDTH-1:0] - b_q;
        last   = busy_q && (cnt_q == CW'(WIDTH - 1));

        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;

        if (start_i) begin
            hi_d   = '0;
            lo_d   = a_i;
            b_d    = b_i;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = (op_i == OP_DIVU) || (op_i == OP_REMU);
        end else if (busy_q) begin
            if (div_q) begin
                // A zero divisor never fails the compare, giving an
                // all-ones quotient and the dividend as remainder.
                if (rem_sh >= {1'b0, b_q}) begin
                    hi_d = diff;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
            cnt_d  = last ? '0 : cnt_q + 1'b1;
            busy_d = !last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end

    assign done_o = last;
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result behind a valid/ready handshake.
// Ports: clk, reset (sync, active high); in_valid/in_ready request side
// with A_in, B_in, ALU_Sel; out_valid/out_ready result side with
// ALU_Out, Zero, Carry_Out, Overflow.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Zero,
    output logic             Carry_Out,
    output logic             Overflow
);

    state_t           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [SHW-1:0]   shamt;

    logic             mdu_start;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_lo;
    logic [WIDTH-1:0] mdu_hi;

    mdu_iter #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_mdu (
        .clk_i  (clk),
        .reset_i(reset),
        .start_i(mdu_start),
        .op_i   (ALU_Sel),
        .a_i    (A_in),
        .b_i    (B_in),
        .done_o (mdu_done),
        .lo_o   (mdu_lo),
        .hi_o   (mdu_hi)
    );

    always_comb begin
        add_s = {1'b0, A_in} + {1'b0, B_in};
        sub_s = {1'b0, A_in} - {1'b0, B_in};
        shamt = B_in[SHW-1:0];
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (ALU_Sel)
            OP_AND: res = A_in & B_in;
            OP_OR:  res = A_in | B_in;
            OP_ADD: begin
                res   = add_s[WIDTH-1:0];
                res_c = add_s[WIDTH];
                res_v = (A_in[WIDTH-1] == B_in[WIDTH-1]) &&
                        (add_s[WIDTH-1] != A_in[WIDTH-1]);
            end
            OP_XOR: res = A_in ^ B_in;
            OP_SLL: res = A_in << shamt;
            OP_SRL: res = A_in >> shamt;
            OP_SUB: begin
                res   = sub_s[WIDTH-1:0];
                res_c = sub_s[WIDTH];
                res_v = (A_in[WIDTH-1] != B_in[WIDTH-1]) &&
                        (sub_s[WIDTH-1] != A_in[WIDTH-1]);
            end
            OP_SLT:
                res = {{(WIDTH-1){1'b0}}, $signed(A_in) < $signed(B_in)};
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: res = '0;
            OP_NOR: res = ~(A_in | B_in);
            OP_SRA: res = $unsigned($signed(A_in) >>> shamt);
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, A_in < B_in};
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, A_in == B_in};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        out_d     = out_q;
        c_d       = c_q;
        v_d       = v_q;
        mdu_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sel_d = ALU_Sel;
                    if (is_iter(ALU_Sel)) begin
                        mdu_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        out_d   = res;
                        c_d     = res_c;
                        v_d     = res_v;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (mdu_done) begin
                    out_d   = ((sel_q == OP_MULHU) || (sel_q == OP_REMU)) ?
                              mdu_hi : mdu_lo;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            out_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ALU_Out   = out_q;
    assign Zero      = (out_q == '0);
    assign Carry_Out = c_q;
    assign Overflow  = v_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's combinational 32-bit ALU.
- Keeps the existing ALU_Sel encodings and the Zero/Carry_Out/Overflow flags.
- Adds XOR, shifts, signed/unsigned compare, and iterative unsigned multiply/divide/remainder.
- Results are registered behind a valid/ready handshake, so the execute stage can stall on long ops.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, at least 8.
- SHW, $clog2(WIDTH), derived; number of low B_in bits used as the shift amount.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- A_in  in  WIDTH  operand A.
- B_in  in  WIDTH  operand B.
- ALU_Sel  in  4  opcode.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- ALU_Out  out  WIDTH  registered result.
- Zero  out  1  high when ALU_Out == 0.
- Carry_Out  out  1  carry/borrow; 0 for non-arithmetic ops.
- Overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL; 0110 SUB; 0111 SLT (signed); 1000 MUL (low WIDTH bits); 1001 MULHU (high WIDTH bits, unsigned); 1010 DIVU; 1011 REMU; 1100 NOR; 1101 SRA; 1110 SLTU; 1111 EQ.
  - No undefined codes remain; every encoding is listed.
- Arithmetic and flag rules:
  - ADD: {Carry_Out,ALU_Out} = A+B, computed at WIDTH+1 bits.
  - SUB: {Carry_Out,ALU_Out} = {0,A} - {0,B}; Carry_Out=1 means borrow.
  - Overflow (ADD/SUB only) = operand/result sign rule.
  - Shifts use B_in[SHW-1:0]; upper B bits are ignored.
  - SLT/SLTU/EQ produce 0 or 1 zero-extended to WIDTH.
- Divide by zero:
  - DIVU returns all-ones; REMU returns A_in.
  - No exception is raised; takes the normal iterative latency.
- Zero is computed from the registered ALU_Out over the full WIDTH.
- FSM states:
  - IDLE: in_ready=1. in_valid=1 latches A, B and Sel. A single-cycle op computes and goes to DONE. MUL/MULHU/DIVU/REMU go to BUSY with counter=0.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle. When counter reaches WIDTH-1, latch the result into DONE.
  - DONE: out_valid=1; outputs are stable while out_ready=0. out_ready=1 returns to IDLE next cycle.
- Latency and throughput:
  - Single-cycle ops: out_valid 1 cycle after the accepting edge.
  - Iterative ops: out_valid WIDTH+1 cycles after the accepting edge.
  - Throughput is at best one op per 2 cycles; no request is accepted in BUSY or DONE.
- in_valid while in_ready=0 is ignored; the requester holds it.
- Operand changes after acceptance have no effect on the result.
- Reset, values and mid-operation behaviour:
  - Reset value of every output: out_valid=0, in_ready=1, ALU_Out=0, Zero=1, Carry_Out=0, Overflow=0.
  - Internal state on reset: state=IDLE, counter=0.
  - Reset in BUSY or DONE aborts the op; no result is ever presented for it.
- Counter is SHW+1 bits wide and never wraps inside an op.

Decomposition:
- Package alu_pkg holds:
  - ALU_Sel opcode localparams.
  - FSM state enum (IDLE/BUSY/DONE).
  - A function is_iter(sel) marking the 4 iterative opcodes.
- Sub-module mdu_iter(WIDTH) holds the shared iterative mul/div datapath.
  - Contents: accumulator, shift register, step counter.
  - Interface: start pulse, op select, done pulse, lo/hi outputs.
- alu_mc holds the single-cycle datapath, flag logic and FSM.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001 -> ALU_Out=0x80000000, Overflow=1, Carry_Out=0, Zero=0; out_valid 1 cycle after accept.
- SUB 3-5 -> 0xFFFFFFFE, Carry_Out=1. SUB 5-5 -> 0, Zero=1. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0. SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000.
- MUL and MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE respectively; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after an ADD result. ALU_Out and flags stay constant; a second in_valid is not accepted. Release -> IDLE next cycle.
  - Assert reset during cycle 10 of a DIVU. Next cycle: out_valid=0, in_ready=1, ALU_Out=0. No result appears afterwards.
